// File: rtl/sync_fifo_buffer.sv
// Single-clock synchronous FIFO used at either end of the two-FIFO transfer path.
// Reads have a fixed one-cycle latency: dout/valid are registered on the edge
// that accepts the read. Flags are decoded from the registered entry count.
// Optional sticky error flags (overflow/underflow) are compiled in when the
// macro SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_buffer #(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned DEPTH_LOG2         = 4,
    parameter int unsigned ALMOST_FULL_MARGIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DEPTH_LOG2:0]   data_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CountFull = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CountAf   = (DEPTH_LOG2 + 1)'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [DEPTH_LOG2:0]   CountOne  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    logic wr_accept;
    logic rd_accept;

    // Flags decoded from the registered count; full is evaluated before the
    // same-cycle read frees a slot, so a write to a full FIFO is always dropped.
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CountFull);
        almost_full = (count_q >= CountAf);
        wr_accept   = wr && !full;
        rd_accept   = rd && !empty;
    end

    // Next-state for pointers, count and the registered read port.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (wr_accept) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (rd_accept) begin
            rptr_d  = rptr_q + PtrOne;
            dout_d  = mem[rptr_q];
            valid_d = 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CountOne;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CountOne;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Storage is not reset; a write during reset lands in an entry that the
    // cleared pointers already treat as free.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign valid      = valid_q;
    assign data_count = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wr & full);
            underflow_q <= underflow_q | (rd & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Self-checking bench for sync_fifo_buffer: a queue model of the FIFO predicts
// flags/count every cycle, and a scoreboard of expected read data is matched
// against each valid pulse. A small vector table covers the simultaneous
// wr/rd corners; hand-written sequences cover fill/drain, overflow, wrap and
// mid-stream reset.
module tb_sync_fifo_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;

    logic           clk;
    logic           reset;
    logic           wr;
    logic [DW-1:0]  din;
    logic           rd;
    logic [DW-1:0]  dout;
    logic           valid;
    logic           empty;
    logic           full;
    logic           almost_full;
    logic [DL2:0]   data_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic           overflow;
    logic           underflow;
`endif

    sync_fifo_buffer #(
        .DATA_WIDTH        (DW),
        .DEPTH_LOG2        (DL2),
        .ALMOST_FULL_MARGIN(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .din        (din),
        .rd         (rd),
        .dout       (dout),
        .valid      (valid),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            exp_count;
        logic          exp_empty;
        logic          exp_full;
        logic          exp_valid;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int  cnt;
        bit  w_ok;
        bit  r_ok;
        wr  = w;
        rd  = r;
        din = d;
        cnt  = model_q.size();
        w_ok = w && (cnt != DEPTH);
        r_ok = r && (cnt != 0);
        if (r_ok) exp_q.push_back(model_q.pop_front());
        if (w_ok) model_q.push_back(d);
        @(posedge clk);
        #1;
        check("valid", valid, r_ok);
        if (r_ok) check("dout", dout, exp_q.pop_front());
        cnt = model_q.size();
        check("data_count", data_count, cnt);
        check("empty", empty, cnt == 0);
        check("full", full, cnt == DEPTH);
        check("almost_full", almost_full, cnt >= DEPTH - 1);
    endtask

    task automatic reset_cycle(input logic w, input logic r);
        reset = 1'b0;
        wr    = w;
        rd    = r;
        din   = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        model_q.delete();
        exp_q.delete();
        check("rst_count", data_count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_valid", valid, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wr       = 1'b0;
        rd       = 1'b0;
        din      = '0;

        //                wr    rd    din    cnt empty full  valid  dout
        vecs[0] = '{1'b1, 1'b1, 8'h5C, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h5C};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h33};

        // Reset, then idle.
        @(posedge clk);
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        check("idle_dout", dout, 8'h00);

        // Simultaneous wr/rd corners, including wr+rd on an empty FIFO.
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check("vec_count", data_count, vecs[i].exp_count);
            check("vec_empty", empty, vecs[i].exp_empty);
            check("vec_full", full, vecs[i].exp_full);
            check("vec_valid", valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check("vec_dout", dout, vecs[i].exp_dout);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("underflow_set", underflow, 1);
        check("overflow_clear", overflow, 0);
`endif

        // Fill with 0x01..0x10 and drain back-to-back.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check("fill_af", almost_full, i >= 15);
            check("fill_full", full, i == 16);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_dout", dout, 8'(i));
        end
        check("drain_empty", empty, 1);
        step(1'b0, 1'b0, 8'h00);
        check("drain_valid_pulse", valid, 0);

        // Full FIFO with wr+rd: read wins, 0xAA dropped.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'hAA);
        check("ovf_count", data_count, 15);
        check("ovf_dout", dout, 8'h01);
        check("ovf_valid", valid, 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow_set", overflow, 1);
`endif
        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("ovf_no_aa", dout != 8'hAA, 1);
        end
        check("ovf_drained", empty, 1);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check("wrap_wcount", data_count, i + 1);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("wrap_dout", dout, 8'(i));
            check("wrap_rcount", data_count, 11 - i);
        end

        // Mid-stream reset with wr and rd asserted.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        reset_cycle(1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        check("post_rst_count", data_count, 0);
        check("post_rst_valid", valid, 0);
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_dout", dout, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buffer.md
Name: sync_fifo_buffer

Overview:
- Single-clock synchronous FIFO that acts as the storage end of the two-FIFO transfer path.
- Accepts `wr`/`rd` strobes from the transfer controller.
- Returns the `empty`, `valid`, `almost_full` and `full` flags the controller consumes.
- Used both as the source FIFO (controller reads) and the sink FIFO (controller writes), so flag timing must match the controller's one-cycle read-to-valid assumption.

Parameters:
- DATA_WIDTH, 8, width of stored words.
- DEPTH_LOG2, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG2 = 16).
- ALMOST_FULL_MARGIN, 1, almost_full asserts when free entries <= this value; legal range 1..DEPTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- wr  input  1  write strobe; din captured when accepted.
- din  input  DATA_WIDTH  write data.
- rd  input  1  read strobe.
- dout  output  DATA_WIDTH  read data, registered.
- valid  output  1  dout holds a word popped on the previous edge.
- empty  output  1  no stored entries.
- full  output  1  DEPTH stored entries.
- almost_full  output  1  count >= DEPTH - ALMOST_FULL_MARGIN.
- data_count  output  DEPTH_LOG2+1  current entry count, 0..DEPTH.

Behaviour:
- State:
  - Storage array of DEPTH words.
  - Write pointer and read pointer, each DEPTH_LOG2 bits, wrapping modulo DEPTH (natural overflow DEPTH-1 -> 0).
  - Count register, DEPTH_LOG2+1 bits.
- Reset (reset==0 at a rising edge):
  - Pointers = 0, count = 0, valid = 0, dout = 0.
  - Hence empty = 1, full = 0, almost_full = 0.
  - Storage contents are don't-care.
  - Reset overrides any concurrent wr/rd.
  - Reset mid-stream discards all entries and any pending valid.
- Write accept = wr && !full. On accept: mem[wptr] <= din, wptr increments.
- Write while full: dropped; no state change.
- Read accept = rd && !empty. On accept: dout <= mem[rptr], rptr increments, valid <= 1 on that edge.
  - Otherwise valid <= 0 and dout holds its last value.
- Read latency: exactly 1 cycle; valid is a one-cycle pulse per accepted read.
- Read while empty: ignored; valid stays 0. No bypass — a word written this cycle is not readable until the next cycle.
- Count update each edge:
  - +1 for write accept only.
  - -1 for read accept only.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr and rd:
  - When full: read accepted, write dropped (full is evaluated before the read frees a slot); count decrements.
  - When empty: write accepted, read ignored; count increments.
  - Otherwise both accepted; count unchanged.
- Flags are decoded combinationally from the registered count, reflecting state after the last edge:
  - empty = (count == 0).
  - full = (count == DEPTH).
  - almost_full = (count >= DEPTH - ALMOST_FULL_MARGIN).
- Ordering: strict FIFO; data_count equals accepted writes minus accepted reads since reset.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, adds outputs `overflow` (1) and `underflow` (1), both sticky and registered.
  - overflow sets on the edge where wr==1 and full==1.
  - underflow sets on the edge where rd==1 and empty==1.
  - Both clear only on reset (0 after reset).
- When undefined: ports absent, no extra logic; dropped writes and ignored reads are silent.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, almost_full=0, valid=0, data_count=0, dout=0.
- Write 0x01..0x10 (16 words), then read 16 times back-to-back:
  - almost_full rises after the 15th write; full rises after the 16th.
  - Each valid pulse arrives 1 cycle after its rd, with dout = 0x01..0x10 in order.
  - empty=1 after the 16th read.
- Fill to 16, assert wr with din=0xAA and rd together for 1 cycle:
  - data_count=15 afterwards, dout=0x01 with valid=1.
  - 0xAA never appears on later reads.
  - overflow=1 if SYNC_FIFO_ERR_FLAGS_EN is defined.
- Empty FIFO, assert wr (din=0x5C) and rd together:
  - No valid pulse that cycle; data_count=1.
  - A read next cycle returns 0x5C.
  - underflow=1 if SYNC_FIFO_ERR_FLAGS_EN is defined.
- Wrap-around: write 10, read 10, then write 12 and read 12:
  - Data 0x00..0x0B returns in order across the pointer wrap.
  - data_count tracks 0..12 with no glitches.
- Load 6 words, drop reset for 1 cycle while wr=1 and rd=1:
  - Next cycle data_count=0, empty=1, valid=0.
  - Sticky flags, when the feature is compiled in, are cleared.
